// File: rtl/obc_shift_accumulator.sv
// OBC shift-accumulator: walks the bit-planes MSB-first, shift-accumulates the ROM-stage
// partial sums, adds the offset term and hands one DFT-bin result downstream.
module obc_shift_accumulator #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 32,
  parameter int ACC_W  = ROM_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROM_W-1:0]          offset,
  output logic [$clog2(DATA_W)-1:0] bit_idx,
  output logic                      m,
  input  logic                      slice_valid,
  output logic                      slice_ready,
  input  logic [ROM_W-1:0]          romout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          result,
  output logic                      busy
);

  // state | meaning
  // IDLE  | waiting for start, slices ignored
  // ACCUM | accepting one slice per handshake, bit_idx counts down
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ROM_W-1:0] off_r;
  logic [ACC_W-1:0] rom_ext;
  logic [ACC_W-1:0] off_ext;
  logic [ACC_W-1:0] acc_next;

  assign rom_ext = ACC_W'($signed(romout));
  assign off_ext = ACC_W'($signed(off_r));

  // The MSB plane restarts the sum so no explicit clear is needed between bins.
  assign acc_next = (bit_idx == LAST_IDX) ? rom_ext : ((acc << 1) + rom_ext);

  assign m = busy && (bit_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      off_r       <= '0;
      bit_idx     <= LAST_IDX;
      out_valid   <= 1'b0;
      result      <= '0;
      slice_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            off_r       <= offset;
            bit_idx     <= LAST_IDX;
            state       <= ACCUM;
            slice_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ACCUM: begin
          if (slice_valid) begin
            acc <= acc_next;
            if (bit_idx == '0) begin
              result      <= acc_next + off_ext;
              out_valid   <= 1'b1;
              bit_idx     <= LAST_IDX;
              state       <= DONE;
              slice_ready <= 1'b0;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              off_r       <= offset;
              state       <= ACCUM;
              slice_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid   <= 1'b0;
          slice_ready <= 1'b0;
          busy        <= 1'b0;
          bit_idx     <= LAST_IDX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: table of bins plus hand-written hold and reset sequences,
// expected results queued at stimulus time and popped at the output handshake.
module tb_obc_shift_accumulator;
  localparam int DATA_W = 16;
  localparam int ROM_W  = 32;
  localparam int ACC_W  = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ROM_W-1:0]  offset;
  logic [3:0]        bit_idx;
  logic              m;
  logic              slice_valid;
  logic              slice_ready;
  logic [ROM_W-1:0]  romout;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              busy;

  obc_shift_accumulator #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .offset(offset), .bit_idx(bit_idx), .m(m),
    .slice_valid(slice_valid), .slice_ready(slice_ready), .romout(romout),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [ACC_W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] off;
    logic [31:0] first;
    logic [31:0] rest;
    bit          gaps;
    logic [47:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one bin; with do_start=0 the caller has already moved the DUT into ACCUM.
  task automatic run_bin(input logic [31:0] off, input logic [31:0] first, input logic [31:0] rest,
                         input bit gaps, input bit do_start, output int lat);
    lat = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1; offset = off;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("slice_ready_accum", 64'(slice_ready), 64'd1);
    for (int i = 0; i < DATA_W; i++) begin
      slice_valid = 1'b1;
      romout = (i == 0) ? first : rest;
      @(negedge clk);
      chk("bit_idx", 64'(bit_idx), 64'(DATA_W - 1 - i));
      chk("m", 64'(m), 64'(i == 0));
      @(posedge clk); lat++; #1;
      if (gaps && (i == 3 || i == 10)) begin
        slice_valid = 1'b0;
        romout = 32'hDEAD_BEEF;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          chk("gap_bit_idx", 64'(bit_idx), 64'(DATA_W - 2 - i));
          chk("gap_m", 64'(m), 64'd0);
          @(posedge clk); lat++; #1;
        end
      end
    end
    slice_valid = 1'b0;
    chk("out_valid_after_last", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_result(input string name);
    int n;
    logic [ACC_W-1:0] e;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no handshake expected one within 50 cycles", name);
    end else if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_unexpected: got result %0h expected none", name, result);
    end else begin
      e = exp_q.pop_front();
      chk(name, 64'(result), 64'(e));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; offset = '0; slice_valid = 1'b0; romout = '0; out_ready = 1'b1;

    vecs[0] = '{32'd0,          32'd1,          32'd1,          1'b0, 48'd65535,           16};
    vecs[1] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          1'b0, 48'hFFFF_FFFF_8005,  16};
    vecs[2] = '{32'd0,          32'd1,          32'd1,          1'b1, 48'd65535,           22};
    vecs[3] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b0, 48'h7FFF_FFFF_0000,  16};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bit_idx", 64'(bit_idx), 64'd15);
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_slice_ready", 64'(slice_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp);
      run_bin(vecs[v].off, vecs[v].first, vecs[v].rest, vecs[v].gaps, 1'b1, lat);
      chk("latency", 64'(lat), 64'(vecs[v].lat));
      wait_result("result");
      chk("out_valid_cleared", 64'(out_valid), 64'd0);
      chk("busy_cleared", 64'(busy), 64'd0);
    end

    // Consumer stalls; start pulses during the stall must be ignored.
    out_ready = 1'b0;
    exp_q.push_back(48'd65538);
    run_bin(32'd3, 32'd1, 32'd1, 1'b0, 1'b1, lat);
    offset = 32'h1234;
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'd65538);
      chk("hold_slice_ready", 64'(slice_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    exp_q.push_back(48'hFFFF_FFFF_8000);
    out_ready = 1'b1; start = 1'b1; offset = 32'd0;
    wait_result("hold_result_taken");
    start = 1'b0;
    chk("b2b_out_valid", 64'(out_valid), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_m", 64'(m), 64'd1);
    run_bin(32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, lat);
    wait_result("b2b_result");

    // Slices in IDLE are ignored.
    slice_valid = 1'b1; romout = 32'd77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_bit_idx", 64'(bit_idx), 64'd15);
    chk("idle_slice_ready", 64'(slice_ready), 64'd0);
    slice_valid = 1'b0;

    // Reset in the middle of a bin.
    @(negedge clk);
    start = 1'b1; offset = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; slice_valid = 1'b1; romout = 32'd5;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bit_idx", 64'(bit_idx), 64'd15);
    chk("mid_rst_m", 64'(m), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_slice_ready", 64'(slice_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    slice_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(48'd131070);
    run_bin(32'd0, 32'd2, 32'd2, 1'b0, 1'b1, lat);
    wait_result("post_rst_result");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_results: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
